// File: rtl/bcp_clause_scanner.sv
// bcp_clause_scanner
// Sequencer for the hardware BCP path. It walks clause memory one clause per
// FETCH/EVAL pair and classifies each clause against the current partial
// assignment. Unit clauses are applied as implications to the internal
// assignment registers. Passes over memory repeat until a pass makes no
// implication (fixpoint) or a conflicting clause is found.
//
// Ports:
//   clock, reset_n          rising-edge clock, synchronous active-low reset
//   start                   begin propagation (accepted in IDLE or DONE only)
//   init_value/assigned     initial partial assignment
//   clause_addr             registered clause memory read address
//   clause_type/mask        clause word, valid one cycle after clause_addr
//   busy, done              FETCH/EVAL, DONE status
//   conflict, conflict_addr result, valid while done=1
//   assign_value, assigned  current partial assignment
//   imply_count             implications made since start (saturating)

module bcp_clause_scanner #(
  parameter int unsigned VAR_NUM    = 8,
  parameter int unsigned CLAUSE_NUM = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [VAR_NUM-1:0] init_value,
  input  logic [VAR_NUM-1:0] init_assigned,
  output logic [ADDR_W-1:0]  clause_addr,
  input  logic [VAR_NUM-1:0] clause_type,
  input  logic [VAR_NUM-1:0] clause_mask,
  output logic               busy,
  output logic               done,
  output logic               conflict,
  output logic [ADDR_W-1:0]  conflict_addr,
  output logic [VAR_NUM-1:0] assign_value,
  output logic [VAR_NUM-1:0] assigned,
  output logic [CNT_W-1:0]   imply_count
);

  typedef enum logic [1:0] {StIdle, StFetch, StEval, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(CLAUSE_NUM - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [VAR_NUM-1:0] value_q, value_d;
  logic [VAR_NUM-1:0] assigned_q, assigned_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               conflict_q, conflict_d;
  logic [ADDR_W-1:0]  caddr_q, caddr_d;
  logic               changed_q, changed_d;

  // Clause evaluation against the current assignment
  logic [VAR_NUM-1:0] true_vec;
  logic [VAR_NUM-1:0] free_vec;
  logic               free_any;
  logic               free_multi;

  always_comb begin
    true_vec   = clause_mask & assigned_q & ~(value_q ^ clause_type);
    free_vec   = clause_mask & ~assigned_q;
    free_any   = 1'b0;
    free_multi = 1'b0;
    for (int i = 0; i < int'(VAR_NUM); i++) begin
      if (free_vec[i]) begin
        if (free_any) free_multi = 1'b1;
        free_any = 1'b1;
      end
    end
  end

  logic is_conflict;
  logic is_unit;

  always_comb begin
    is_conflict = 1'b0;
    is_unit     = 1'b0;
    // Empty clauses are skipped; satisfied clauses have no effect.
    if ((|clause_mask) && !(|true_vec)) begin
      is_conflict = !free_any;
      is_unit     = free_any && !free_multi;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    value_d    = value_q;
    assigned_d = assigned_q;
    count_d    = count_q;
    conflict_d = conflict_q;
    caddr_d    = caddr_q;
    changed_d  = changed_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          assigned_d = init_assigned;
          value_d    = init_value & init_assigned;
          count_d    = '0;
          conflict_d = 1'b0;
          caddr_d    = '0;
          changed_d  = 1'b0;
          addr_d     = '0;
          state_d    = StFetch;
        end
      end

      StFetch: state_d = StEval;

      StEval: begin
        if (is_conflict) begin
          conflict_d = 1'b1;
          caddr_d    = addr_q;
          state_d    = StDone;
        end else begin
          if (is_unit) begin
            // free_vec is one-hot here: it marks the implied variable.
            assigned_d = assigned_q | free_vec;
            value_d    = (value_q & ~free_vec) | (clause_type & free_vec);
            if (count_q != '1) count_d = count_q + CNT_W'(1);
            changed_d  = 1'b1;
          end
          if (addr_q != LastAddr) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StFetch;
          end else if (changed_q || is_unit) begin
            // An implication on the last clause also forces another pass.
            addr_d    = '0;
            changed_d = 1'b0;
            state_d   = StFetch;
          end else begin
            state_d = StDone;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      value_q    <= '0;
      assigned_q <= '0;
      count_q    <= '0;
      conflict_q <= 1'b0;
      caddr_q    <= '0;
      changed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      value_q    <= value_d;
      assigned_q <= assigned_d;
      count_q    <= count_d;
      conflict_q <= conflict_d;
      caddr_q    <= caddr_d;
      changed_q  <= changed_d;
    end
  end

  assign clause_addr   = addr_q;
  assign busy          = (state_q == StFetch) || (state_q == StEval);
  assign done          = (state_q == StDone);
  assign conflict      = conflict_q;
  assign conflict_addr = caddr_q;
  assign assign_value  = value_q;
  assign assigned      = assigned_q;
  assign imply_count   = count_q;

endmodule

// File: tb/tb_bcp_clause_scanner.sv
// Bench for bcp_clause_scanner with VAR_NUM=4, CLAUSE_NUM=4. Stimulus pushes the
// hand-computed result of each accepted run onto a queue; a monitor pops it
// when done rises and compares result registers and start-to-done latency.

module tb_bcp_clause_scanner;

  localparam int unsigned VN = 4;
  localparam int unsigned CN = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned CW = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [VN-1:0] init_value = '0;
  logic [VN-1:0] init_assigned = '0;
  logic [AW-1:0] clause_addr;
  logic [VN-1:0] clause_type;
  logic [VN-1:0] clause_mask;
  logic          busy;
  logic          done;
  logic          conflict;
  logic [AW-1:0] conflict_addr;
  logic [VN-1:0] assign_value;
  logic [VN-1:0] assigned;
  logic [CW-1:0] imply_count;

  bcp_clause_scanner #(
    .VAR_NUM   (VN),
    .CLAUSE_NUM(CN),
    .ADDR_W    (AW),
    .CNT_W     (CW)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .init_value   (init_value),
    .init_assigned(init_assigned),
    .clause_addr  (clause_addr),
    .clause_type  (clause_type),
    .clause_mask  (clause_mask),
    .busy         (busy),
    .done         (done),
    .conflict     (conflict),
    .conflict_addr(conflict_addr),
    .assign_value (assign_value),
    .assigned     (assigned),
    .imply_count  (imply_count)
  );

  always #5 clock = ~clock;

  // Clause memory with one-cycle registered read
  logic [VN-1:0] mem_m [CN];
  logic [VN-1:0] mem_t [CN];

  always @(posedge clock) begin
    clause_mask <= mem_m[clause_addr];
    clause_type <= mem_t[clause_addr];
  end

  int cyc = 0;
  int start_cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    string         name;
    int            lat;
    logic          conf;
    logic [AW-1:0] caddr;
    logic [VN-1:0] asg;
    logic [VN-1:0] val;
    logic [CW-1:0] cnt;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endfunction

  function automatic void expect_run(string n, int lat, logic conf, logic [AW-1:0] ca,
                                     logic [VN-1:0] asg, logic [VN-1:0] val,
                                     logic [CW-1:0] cnt, logic [AW-1:0] addr);
    exp_t e;
    e.name = n; e.lat = lat; e.conf = conf; e.caddr = ca;
    e.asg = asg; e.val = val; e.cnt = cnt; e.addr = addr;
    sb.push_back(e);
  endfunction

  // Monitor: compare on each rising edge of done
  logic done_prev = 1'b0;
  always @(negedge clock) begin : mon
    exp_t e;
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done=1 with no run pending");
      end else begin
        e = sb.pop_front();
        chk({e.name, "_latency"}, cyc - start_cyc, e.lat);
        chk({e.name, "_conflict"}, conflict, e.conf);
        chk({e.name, "_conflict_addr"}, conflict_addr, e.caddr);
        chk({e.name, "_assigned"}, assigned, e.asg);
        chk({e.name, "_assign_value"}, assign_value, e.val);
        chk({e.name, "_imply_count"}, imply_count, e.cnt);
        chk({e.name, "_clause_addr"}, clause_addr, e.addr);
      end
    end
    done_prev <= done;
  end

  task automatic clear_mem();
    for (int i = 0; i < int'(CN); i++) begin
      mem_m[i] = '0;
      mem_t[i] = '0;
    end
  endtask

  task automatic launch(input logic [VN-1:0] ia, input logic [VN-1:0] iv);
    @(negedge clock);
    init_assigned = ia;
    init_value    = iv;
    start         = 1'b1;
    @(posedge clock);
    #1;
    start_cyc = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, input logic [AW-1:0] hold);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!done) begin
      checks++;
      $display("FAIL %s_timeout: got done=0 after %0d cycles, required done=1", name, budget);
    end else begin
      repeat (3) @(negedge clock);
      chk({name, "_addr_hold"}, clause_addr, hold);
      chk({name, "_done_hold"}, done, 1'b1);
    end
  endtask

  task automatic chk_cleared(input string name);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_done"}, done, 1'b0);
    chk({name, "_conflict"}, conflict, 1'b0);
    chk({name, "_conflict_addr"}, conflict_addr, 0);
    chk({name, "_clause_addr"}, clause_addr, 0);
    chk({name, "_assigned"}, assigned, 0);
    chk({name, "_assign_value"}, assign_value, 0);
    chk({name, "_imply_count"}, imply_count, 0);
  endtask

  initial begin
    clear_mem();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk_cleared("reset");
    reset_n = 1'b1;

    // 1: all clauses satisfied, one clean pass
    for (int i = 0; i < int'(CN); i++) begin
      mem_m[i] = 4'b0011;
      mem_t[i] = 4'b0011;
    end
    expect_run("s1", 8, 1'b0, 2'd0, 4'b1111, 4'b1111, 3'd0, 2'd3);
    launch(4'b1111, 4'b1111);
    wait_done("s1", 100, 2'd3);

    // 2: forward chain; unassigned init_value bits must be forced to 0
    clear_mem();
    mem_m[0] = 4'b0001; mem_t[0] = 4'b0001;
    mem_m[1] = 4'b0011; mem_t[1] = 4'b0010;
    expect_run("s2", 16, 1'b0, 2'd0, 4'b0011, 4'b0011, 3'd2, 2'd3);
    launch(4'b0000, 4'b1010);
    wait_done("s2", 100, 2'd3);

    // 3: backward chain, with a start pulse while busy that must be ignored
    clear_mem();
    mem_m[0] = 4'b0110; mem_t[0] = 4'b0100;
    mem_m[1] = 4'b0010; mem_t[1] = 4'b0010;
    expect_run("s3", 24, 1'b0, 2'd0, 4'b0110, 4'b0110, 3'd2, 2'd3);
    launch(4'b0000, 4'b0000);
    repeat (4) @(negedge clock);
    chk("s3_busy_mid", busy, 1'b1);
    init_assigned = 4'b1111;
    init_value    = 4'b1111;
    start         = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done("s3", 100, 2'd3);

    // 4: conflict on clause 1
    clear_mem();
    mem_m[0] = 4'b0001; mem_t[0] = 4'b0001;
    mem_m[1] = 4'b0001; mem_t[1] = 4'b0000;
    expect_run("s4", 4, 1'b1, 2'd1, 4'b0001, 4'b0001, 3'd1, 2'd1);
    launch(4'b0000, 4'b0000);
    wait_done("s4", 100, 2'd1);

    // 6: restart from DONE, immediate conflict at address 0
    clear_mem();
    mem_m[0] = 4'b0001; mem_t[0] = 4'b0001;
    expect_run("s6", 2, 1'b1, 2'd0, 4'b0001, 4'b0000, 3'd0, 2'd0);
    launch(4'b0001, 4'b0000);
    wait_done("s6", 100, 2'd0);

    // 5: reset mid-scan of scenario 2, then a clean rerun
    clear_mem();
    mem_m[0] = 4'b0001; mem_t[0] = 4'b0001;
    mem_m[1] = 4'b0011; mem_t[1] = 4'b0010;
    launch(4'b0000, 4'b1010);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    chk_cleared("s5_reset");
    repeat (2) @(negedge clock);
    chk("s5_idle_addr", clause_addr, 0);
    chk("s5_idle_busy", busy, 1'b0);
    expect_run("s5", 16, 1'b0, 2'd0, 4'b0011, 4'b0011, 3'd2, 2'd3);
    launch(4'b0000, 4'b1010);
    wait_done("s5", 100, 2'd3);

    repeat (2) @(negedge clock);
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL pending_runs: got %0d unchecked runs, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
